la_cellbist4: RTL and testbench



---
 rtl/la_cellbist4.sv | 112 +++++++++++
 tb/tb_la_cellbist4.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/la_cellbist4.sv
// la_cellbist4: built-in self-test harness for 4-input cells. It steps {d,c,b,a} through 0..15 and checks z against TRUTH.
// Optional feature: define LA_CELLBIST_STOPONFAIL_EN to end the run on the first mismatching pattern.
module la_cellbist4 #(
   parameter              PROP   = "DEFAULT",
   parameter logic [15:0] TRUTH  = 16'h7FFF,
   parameter int          SETTLE = 2
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic       start,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   input  logic       z,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [4:0] err_count,
   output logic       fail_valid,
   output logic [3:0] fail_index
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_CHECK = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

   generate
      if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
         $error("la_cellbist4 (%s): SETTLE=%0d is outside 1..15", PROP, SETTLE);
      end
   endgenerate

   logic [1:0] r_state;
   logic [3:0] r_idx;
   logic [3:0] r_cnt;
   logic [4:0] r_err;
   logic       r_fv;
   logic [3:0] r_fi;
   logic       w_miss;
   logic       w_last;

   assign w_miss = (z != TRUTH[r_idx]);

`ifdef LA_CELLBIST_STOPONFAIL_EN
   assign w_last = (r_idx == 4'd15) || w_miss;
`else
   assign w_last = (r_idx == 4'd15);
`endif

   // r_idx drives the cell inputs directly from flops, so the pattern never glitches
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state <= S_IDLE;
         r_idx   <= 4'd0;
         r_cnt   <= 4'd0;
         r_err   <= 5'd0;
         r_fv    <= 1'b0;
         r_fi    <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state <= S_WAIT;
                  r_idx   <= 4'd0;
                  r_cnt   <= SETTLE_LOAD;
                  r_err   <= 5'd0;
                  r_fv    <= 1'b0;
                  r_fi    <= 4'd0;
               end
            end
            S_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state <= S_CHECK;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_CHECK: begin
               if (w_miss) begin
                  r_err <= r_err + 5'd1;
                  if (!r_fv) begin
                     r_fv <= 1'b1;
                     r_fi <= r_idx;
                  end
               end
               if (w_last) begin
                  r_state <= S_DONE;
                  r_idx   <= 4'd0;
               end else begin
                  r_state <= S_WAIT;
                  r_idx   <= r_idx + 4'd1;
                  r_cnt   <= SETTLE_LOAD;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign {d, c, b, a} = r_idx;
   assign busy         = (r_state == S_WAIT) || (r_state == S_CHECK);
   assign done         = (r_state == S_DONE);
   assign pass         = done && (r_err == 5'd0);
   assign err_count    = r_err;
   assign fail_valid   = r_fv;
   assign fail_index   = r_fi;

endmodule

// File: tb/tb_la_cellbist4.sv
// Bench for la_cellbist4: a default nand4 instance and an and4/SETTLE=1 instance, each checked every cycle
// against a run-time model built from pattern counts and mismatch masks.
module tb_la_cellbist4;

`ifdef LA_CELLBIST_STOPONFAIL_EN
   localparam bit SOF = 1'b1;
`else
   localparam bit SOF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        nreset;
   logic        chk_en;
   logic        st       [2];
   logic [15:0] cm       [2];
   logic        busy_w   [2];
   logic        done_w   [2];
   logic        pass_w   [2];
   logic [4:0]  err_w    [2];
   logic        fv_w     [2];
   logic [3:0]  fi_w     [2];
   logic [3:0]  pat_w    [2];

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   function automatic logic [15:0] truth_of(input int g);
      return (g == 0) ? 16'h7FFF : 16'h8000;
   endfunction

   // mismatches among the first c patterns
   function automatic int errs(input logic [15:0] m, input int c);
      int n = 0;
      for (int i = 0; i < c; i++) if (m[i]) n++;
      return n;
   endfunction

   function automatic int first(input logic [15:0] m, input int c);
      for (int i = 0; i < c; i++) if (m[i]) return i;
      return 0;
   endfunction

   function automatic int durf(input logic [15:0] m, input int p);
      if (SOF && m != 16'h0) return (first(m, 16) + 1) * p;
      return 16 * p;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int          S = (g == 0) ? 2 : 1;
      localparam int          P = S + 1;
      localparam logic [15:0] T = (g == 0) ? 16'h7FFF : 16'h8000;

      logic w_a, w_b, w_c, w_d, w_z;

      la_cellbist4 #(.PROP("DEFAULT"), .TRUTH(T), .SETTLE(S)) u_dut (
         .clk        (clk),
         .nreset     (nreset),
         .start      (st[g]),
         .a          (w_a),
         .b          (w_b),
         .c          (w_c),
         .d          (w_d),
         .z          (w_z),
         .busy       (busy_w[g]),
         .done       (done_w[g]),
         .pass       (pass_w[g]),
         .err_count  (err_w[g]),
         .fail_valid (fv_w[g]),
         .fail_index (fi_w[g])
      );

      assign pat_w[g] = {w_d, w_c, w_b, w_a};
      assign w_z      = cm[g][pat_w[g]];

      logic        m_run;
      logic        m_done;
      int          m_t;
      logic [15:0] m_mask;

      always @(posedge clk or negedge nreset) begin
         if (!nreset) begin
            m_run  <= 1'b0;
            m_done <= 1'b0;
            m_t    <= 0;
            m_mask <= 16'h0;
         end else if (!m_run) begin
            if (st[g]) begin
               m_run  <= 1'b1;
               m_done <= 1'b0;
               m_t    <= 0;
               m_mask <= cm[g] ^ T;
            end
         end else if (m_t == durf(m_mask, P) - 1) begin
            m_run  <= 1'b0;
            m_done <= 1'b1;
         end else begin
            m_t <= m_t + 1;
         end
      end

      always @(negedge clk) begin
         int          c;
         int          e_err;
         logic [3:0]  e_pat;
         logic [16:0] e_v;
         logic [16:0] a_v;
         if (chk_en) begin
            c     = m_done ? durf(m_mask, P) / P : (m_run ? m_t / P : 0);
            e_err = errs(m_mask, c);
            e_pat = m_run ? 4'(m_t / P) : 4'd0;
            e_v   = {m_run, m_done, m_done && (e_err == 0), e_pat, 5'(e_err),
                     (e_err != 0), 4'(first(m_mask, c))};
            a_v   = {busy_w[g], done_w[g], pass_w[g], pat_w[g], err_w[g], fv_w[g], fi_w[g]};
            n_vec++;
            if (a_v !== e_v) begin
               n_bad++;
               $display("FAIL outs[g%0d] t=%0t got busy/done/pass/pat/err/fv/fi=%h want %h", g, $time, a_v, e_v);
            end
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   task automatic run(input int g, input logic [15:0] m, input bit poke, output int n);
      cm[g] = m;
      @(posedge clk); #1 st[g] = 1'b1;
      @(posedge clk); #1 st[g] = 1'b0;
      n = 0;
      while (!done_w[g] && n < 200) begin
         @(posedge clk); #1;
         n++;
         if (poke && n == 10) st[g] = 1'b1;
         if (poke && n == 11) st[g] = 1'b0;
      end
      chk("run_completes", int'(done_w[g]), 1);
   endtask

   initial begin
      int n;
      int k;
      int g;
      nreset = 1'b0;
      chk_en = 1'b0;
      st[0] = 1'b0; st[1] = 1'b0;
      cm[0] = 16'h7FFF; cm[1] = 16'h8000;
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      chk("reset_busy", int'(busy_w[0]), 0);
      chk("reset_err", int'(err_w[0]), 0);
      chk("reset_pat", int'(pat_w[0]), 0);
      nreset = 1'b1;

      run(0, 16'h7FFF, 1'b0, n);
      chk("nand4_len", n, 48);
      chk("nand4_pass", int'(pass_w[0]), 1);
      chk("nand4_err", int'(err_w[0]), 0);
      chk("nand4_fv", int'(fv_w[0]), 0);

      run(0, 16'hFFFF, 1'b0, n);
      chk("stuck1_pass", int'(pass_w[0]), 0);
      chk("stuck1_err", int'(err_w[0]), 1);
      chk("stuck1_fv", int'(fv_w[0]), 1);
      chk("stuck1_fi", int'(fi_w[0]), 15);

      run(0, 16'h0000, 1'b0, n);
      chk("stuck0_err", int'(err_w[0]), SOF ? 1 : 15);
      chk("stuck0_fi", int'(fi_w[0]), 0);
      chk("stuck0_len", n, SOF ? 3 : 48);

      run(1, 16'h8000, 1'b0, n);
      chk("and4_len", n, 32);
      chk("and4_pass", int'(pass_w[1]), 1);

      run(0, 16'h7FFF, 1'b1, n);
      chk("poke_len", n, 48);

      // abort a failing run at pattern 7, then confirm a clean rerun
      cm[0] = 16'hFFFF;
      @(posedge clk); #1 st[0] = 1'b1;
      @(posedge clk); #1 st[0] = 1'b0;
      k = 0;
      while (pat_w[0] != 4'd7 && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      chk("reach_pat7", int'(pat_w[0]), 7);
      #2 nreset = 1'b0;
      #1;
      chk("abort_busy", int'(busy_w[0]), 0);
      chk("abort_pat", int'(pat_w[0]), 0);
      chk("abort_err", int'(err_w[0]), 0);
      chk("abort_fv", int'(fv_w[0]), 0);
      @(posedge clk); #1 nreset = 1'b1;
      run(0, 16'h7FFF, 1'b0, n);
      chk("rerun_len", n, 48);
      chk("rerun_pass", int'(pass_w[0]), 1);

      for (int i = 0; i < 10; i++) begin
         g = int'($urandom_range(0, 1));
         run(g, truth_of(g) ^ 16'($urandom & $urandom & $urandom), 1'($urandom_range(0, 1)), n);
         repeat (int'($urandom_range(0, 3))) @(posedge clk);
      end

      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
